// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: font table,
// dark pattern and parameter legality check.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {a,b,c,d,e,f,g}, indexed by nibble.
  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic bit params_ok(
    input int n,
    input int sdb,
    input int blank,
    input int pwm,
    input int bdb
  );
    if (n < 1 || n > 8) return 1'b0;
    if (sdb < 1 || sdb > 30) return 1'b0;
    if (blank < 0 || blank >= (1 << sdb)) return 1'b0;
    if (pwm < 1 || pwm > sdb) return 1'b0;
    if (bdb < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Nibble to active-low 7-segment pattern.
// Ports: nibble in (4), pattern out {a..g} (7).
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = FONT[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-seg driver: blink, blank, dp,
// leading-zero suppression, PWM brightness, ghost-blank gap.
// Ports: clk100M, rst (async high), value/dp_in/blank_in/blink_in,
// lz_suppress, brightness in; EN (anodes), SEGs {a..g,dp} out, active-low.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV_BITS  = 18,
  parameter int BLANK_CYCLES   = 64,
  parameter int PWM_BITS       = 4,
  parameter int BLINK_DIV_BITS = 26
) (
  input  logic                    clk100M,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   EN,
  output logic [7:0]              SEGs
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_DIV_BITS-1:0] BLANK_C =
    SCAN_DIV_BITS'(BLANK_CYCLES);

  if (!params_ok(NUM_DIGITS, SCAN_DIV_BITS, BLANK_CYCLES,
                 PWM_BITS, BLINK_DIV_BITS)) begin : g_bad_params
    $error("seg7_scan_display: illegal parameter set");
  end

  logic [SCAN_DIV_BITS-1:0]  slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BLINK_DIV_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                      blink_phase_q, blink_phase_d;

  logic [VW-1:0]         val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] blnk_q, blnk_d;
  logic                  lz_q, lz_d;

  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [7:0]            segs_q, segs_d;

  logic                  take;
  logic [NUM_DIGITS-1:0] supp;
  logic                  all_zero;
  logic [IDX_W-1:0]      dig;
  logic [3:0]            nib;
  logic [6:0]            font_pat;
  logic                  pwm_on;
  logic                  lit;

  always_comb begin : next_state
    take = (slot_cnt_q == '0) && (idx_q == '0);
    slot_cnt_d = slot_cnt_q + SCAN_DIV_BITS'(1);
    idx_d = idx_q;
    if (&slot_cnt_q) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    blink_cnt_d = blink_cnt_q + BLINK_DIV_BITS'(1);
    blink_phase_d = blink_phase_q ^ (&blink_cnt_q);
    // The *_d snapshot is what this cycle displays, so the
    // frame's first slot already sees the freshly sampled inputs.
    val_d   = val_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    blnk_d  = blnk_q;
    lz_d    = lz_q;
    if (take) begin
      val_d   = value;
      dp_d    = dp_in;
      blank_d = blank_in;
      blnk_d  = blink_in;
      lz_d    = lz_suppress;
    end
  end

  // Walk down from the top digit; digit 0 is never suppressed.
  always_comb begin : lz_mask
    supp = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (val_d[4*i +: 4] == 4'h0);
      supp[i] = lz_d & all_zero;
    end
  end

  // Slot k shows digit N-1-k: most significant first.
  assign dig = LAST_IDX - idx_q;
  assign nib = 4'(val_d >> {dig, 2'b00});

  seg7_hex_font u_font (
    .nibble  (nib),
    .pattern (font_pat)
  );

  always_comb begin : out_next
    en_d   = '1;
    segs_d = SEG_OFF;
    pwm_on = (&brightness) ||
             (slot_cnt_q[PWM_BITS-1:0] < brightness);
    lit = (slot_cnt_q >= BLANK_C) && pwm_on &&
          !blank_d[dig] &&
          !(blnk_d[dig] && blink_phase_q) &&
          !supp[dig];
    if (lit) begin
      en_d[dig] = 1'b0;
      segs_d = {font_pat, ~dp_d[dig]};
    end
  end

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      val_q         <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      blnk_q        <= '0;
      lz_q          <= 1'b0;
      en_q          <= '1;
      segs_q        <= SEG_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      val_q         <= val_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      blnk_q        <= blnk_d;
      lz_q          <= lz_d;
      en_q          <= en_d;
      segs_q        <= segs_d;
    end
  end

  assign EN   = en_q;
  assign SEGs = segs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: time-indexed reference model,
// directed scenarios and randomized input changes.
module tb_seg7_scan_display;

  localparam int N      = 4;
  localparam int SDB    = 4;
  localparam int BLANK  = 2;
  localparam int PWB    = 2;
  localparam int BDB    = 8;
  localparam int SLOT   = 1 << SDB;
  localparam int FRAME  = SLOT * N;
  localparam int BLINKP = 1 << BDB;

  logic        clk100M = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  blink_in = '0;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  EN;
  logic [7:0]  SEGs;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int lit_cnt = 0;

  logic [15:0] s_val;
  logic [3:0]  s_dp, s_blank, s_blink;
  logic        s_lz;

  seg7_scan_display #(
    .NUM_DIGITS     (N),
    .SCAN_DIV_BITS  (SDB),
    .BLANK_CYCLES   (BLANK),
    .PWM_BITS       (PWB),
    .BLINK_DIV_BITS (BDB)
  ) dut (
    .clk100M     (clk100M),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .blink_in    (blink_in),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .EN          (EN),
    .SEGs        (SEGs)
  );

  always #5 clk100M = ~clk100M;

  task automatic check(string tag, logic [11:0] got,
                       logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)",
               tag, got, exp, t);
    end
  endtask

  function automatic logic [6:0] hex_font(logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Expected {EN,SEGs} after the edge taken at time tt.
  function automatic logic [11:0] model(int tt);
    int slot, d;
    bit ph, pwm, supp, lit;
    logic [3:0] nib, en;
    slot = tt % SLOT;
    d    = N - 1 - ((tt / SLOT) % N);
    ph   = ((tt / BLINKP) % 2) == 1;
    pwm  = (brightness == 2'd3) ||
           ((slot % (1 << PWB)) < int'(brightness));
    nib  = s_val[4*d +: 4];
    supp = s_lz && (d != 0) && ((s_val >> (4*d)) == 16'h0);
    lit  = (slot >= BLANK) && pwm && !s_blank[d] &&
           !(s_blink[d] && ph) && !supp;
    if (!lit) return 12'hFFF;
    en = 4'hF;
    en[d] = 1'b0;
    return {en, hex_font(nib), ~s_dp[d]};
  endfunction

  task automatic step(string tag);
    @(posedge clk100M);
    @(negedge clk100M);
    if (t % FRAME == 0) begin
      s_val   = value;
      s_dp    = dp_in;
      s_blank = blank_in;
      s_blink = blink_in;
      s_lz    = lz_suppress;
    end
    check(tag, {EN, SEGs}, model(t));
    if (EN != 4'hF) lit_cnt++;
    t++;
  endtask

  task automatic run(string tag, int n);
    repeat (n) step(tag);
  endtask

  task automatic align(int m);
    while (t % m != 0) step("align");
  endtask

  task automatic set_in(logic [15:0] v, logic [3:0] dp,
                        logic [3:0] bl, logic [3:0] bk,
                        logic lz, logic [1:0] br);
    value = v;
    dp_in = dp;
    blank_in = bl;
    blink_in = bk;
    lz_suppress = lz;
    brightness = br;
  endtask

  task automatic release_rst();
    @(negedge clk100M);
    rst = 1'b0;
    t = 0;
    s_val = '0;
    s_dp = '0;
    s_blank = '0;
    s_blink = '0;
    s_lz = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk100M);
    check("reset_state", {EN, SEGs}, 12'hFFF);
    set_in(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
    release_rst();

    lit_cnt = 0;
    run("full_12AF", FRAME);
    check("lit_full", 12'(lit_cnt), 12'd56);

    brightness = 2'd1;
    lit_cnt = 0;
    run("pwm1", FRAME);
    check("lit_pwm1", 12'(lit_cnt), 12'd12);

    brightness = 2'd0;
    lit_cnt = 0;
    run("pwm0", FRAME);
    check("lit_pwm0", 12'(lit_cnt), 12'd0);

    align(FRAME);
    set_in(16'h0070, 4'b1000, 4'h0, 4'h0, 1'b1, 2'd3);
    lit_cnt = 0;
    run("lz_0070", FRAME);
    check("lit_lz70", 12'(lit_cnt), 12'd28);
    value = 16'h0000;
    lit_cnt = 0;
    run("lz_0000", FRAME);
    check("lit_lz0", 12'(lit_cnt), 12'd14);

    set_in(16'h12AF, 4'h0, 4'h0, 4'b0001, 1'b0, 2'd3);
    align(2 * BLINKP);
    lit_cnt = 0;
    run("blink_ph0", BLINKP);
    check("lit_blink0", 12'(lit_cnt), 12'd224);
    lit_cnt = 0;
    run("blink_ph1", BLINKP);
    check("lit_blink1", 12'(lit_cnt), 12'd168);

    set_in(16'h3C5E, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
    align(FRAME);
    run("mid_old", SLOT + SLOT / 2);
    value = 16'hB0D9;
    run("mid_chg", FRAME + FRAME / 2);

    for (int i = 0; i < 40; i++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 1'($urandom), 2'($urandom));
      if (i % 3 == 0) value = value & 16'h00FF;
      run("random", int'($urandom_range(1, 100)));
    end

    set_in(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
    align(FRAME);
    run("pre_rst", 2 * SLOT + 7);
    #1 rst = 1'b1;
    #1 check("rst_async", {EN, SEGs}, 12'hFFF);
    @(posedge clk100M);
    #1 check("rst_hold", {EN, SEGs}, 12'hFFF);
    release_rst();
    run("restart", BLANK + 1);
    check("restart_dig3", {8'h00, EN}, 12'h007);
    run("restart", FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
